stream_mux_nto1: RTL and testbench

//  Parametrised N-to-1 stream multiplexer with a valid/ready handshake on every port.

---
 rtl/stream_mux_nto1.sv | 167 ++++++++++++++++
 tb/tb_stream_mux_nto1.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_nto1.sv
// N-to-1 valid/ready stream multiplexer with fixed-select or round-robin arbitration
// and a single registered output stage. Define STREAM_MUX_LOCK_EN to add packet locking.
module stream_mux_nto1 #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    mode_i,
  input  logic [SEL_W-1:0]        sel_i,
  input  logic [NUM_CH*WIDTH-1:0] data_i,
  input  logic [NUM_CH-1:0]       valid_i,
  output logic [NUM_CH-1:0]       ready_o,
`ifdef STREAM_MUX_LOCK_EN
  input  logic [NUM_CH-1:0]       last_i,
  output logic                    last_o,
`endif
  output logic [WIDTH-1:0]        data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [SEL_W-1:0]        chan_o,
  output logic [SEL_W-1:0]        dbg_ptr,
  output logic                    dbg_locked
);

  // Handshake: a beat moves on any port in a cycle where valid and ready are both
  // high at the rising edge; a producer holds data stable while valid && !ready.

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_gnt;
  logic             rr_vld;
  logic             fixed_vld;
  logic [SEL_W-1:0] gnt;
  logic             gnt_vld;
  logic             out_free;
  logic             accept;
  logic [WIDTH-1:0] gnt_data;

  function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_CH) s = s - NUM_CH;
    return SEL_W'(s);
  endfunction

  // Round-robin search starts at ptr and wraps, so the last winner gets lowest priority.
  always_comb begin
    rr_vld = 1'b0;
    rr_gnt = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!rr_vld && valid_i[wrap_idx(ptr, k)]) begin
        rr_vld = 1'b1;
        rr_gnt = wrap_idx(ptr, k);
      end
    end
  end

  assign fixed_vld = (int'(sel_i) < NUM_CH);
  assign out_free  = !valid_o || ready_i;

`ifdef STREAM_MUX_LOCK_EN
  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t           state;
  logic [SEL_W-1:0] lock_ch;
  logic             gnt_last;

  always_comb begin
    if (state == ST_LOCKED) begin
      gnt     = lock_ch;
      gnt_vld = 1'b1;
    end else if (mode_i) begin
      gnt     = rr_gnt;
      gnt_vld = rr_vld;
    end else begin
      gnt     = sel_i;
      gnt_vld = fixed_vld;
    end
  end

  always_comb begin
    gnt_last = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt == SEL_W'(c)) gnt_last = last_i[c];
    end
  end

  // Packet lock: a beat without last pins the grant to its channel until last arrives.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      lock_ch <= '0;
    end else if (accept) begin
      case (state)
        ST_IDLE: begin
          if (!gnt_last) begin
            state   <= ST_LOCKED;
            lock_ch <= gnt;
          end
        end
        ST_LOCKED: begin
          if (gnt_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_locked = (state == ST_LOCKED);
`else
  always_comb begin
    if (mode_i) begin
      gnt     = rr_gnt;
      gnt_vld = rr_vld;
    end else begin
      gnt     = sel_i;
      gnt_vld = fixed_vld;
    end
  end

  assign dbg_locked = 1'b0;
`endif

  // In fixed mode ready_o depends on sel_i and the output stage only, never on valid_i.
  always_comb begin
    ready_o  = '0;
    gnt_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt == SEL_W'(c)) begin
        ready_o[c] = gnt_vld && out_free;
        gnt_data   = data_i[c*WIDTH +: WIDTH];
      end
    end
  end

  assign accept = |(valid_i & ready_o);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      chan_o  <= '0;
      ptr     <= '0;
`ifdef STREAM_MUX_LOCK_EN
      last_o  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        valid_o <= 1'b1;
        data_o  <= gnt_data;
        chan_o  <= gnt;
`ifdef STREAM_MUX_LOCK_EN
        last_o  <= gnt_last;
`endif
        if (mode_i) begin
          ptr <= (gnt == SEL_W'(NUM_CH - 1)) ? '0 : gnt + SEL_W'(1);
        end
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

  assign dbg_ptr = ptr;

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Directed self-checking bench for stream_mux_nto1 (NUM_CH=4, WIDTH=8); the packet-lock
// sequence is exercised only when STREAM_MUX_LOCK_EN is defined.
module tb_stream_mux_nto1;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;
  localparam int SEL_W  = 2;

  logic                    clk;
  logic                    rst;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_CH*WIDTH-1:0] data_in;
  logic [NUM_CH-1:0]       valid_in;
  logic [NUM_CH-1:0]       ready_out;
  logic [WIDTH-1:0]        data_out;
  logic                    valid_out;
  logic                    ready_in;
  logic [SEL_W-1:0]        chan_out;
  logic [SEL_W-1:0]        dbg_ptr;
  logic                    dbg_locked;
`ifdef STREAM_MUX_LOCK_EN
  logic [NUM_CH-1:0]       last_in;
  logic                    last_out;
`endif

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_b;

  stream_mux_nto1 #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .mode_i     (mode),
    .sel_i      (sel),
    .data_i     (data_in),
    .valid_i    (valid_in),
    .ready_o    (ready_out),
`ifdef STREAM_MUX_LOCK_EN
    .last_i     (last_in),
    .last_o     (last_out),
`endif
    .data_o     (data_out),
    .valid_o    (valid_out),
    .ready_i    (ready_in),
    .chan_o     (chan_out),
    .dbg_ptr    (dbg_ptr),
    .dbg_locked (dbg_locked)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_data(input int c, input logic [WIDTH-1:0] v);
    data_in[c*WIDTH +: WIDTH] = v;
  endtask

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    mode     = 1'b0;
    sel      = '0;
    data_in  = '0;
    valid_in = '0;
    ready_in = 1'b0;
`ifdef STREAM_MUX_LOCK_EN
    last_in  = '0;
`endif
    tick();
    tick();
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_chan", 32'(chan_out), 32'h0);
    chk("rst_ptr", 32'(dbg_ptr), 32'h0);
    chk("rst_locked", 32'(dbg_locked), 32'h0);
    rst = 1'b0;
    tick();

    // Fixed select, single beat on ch2
    mode = 1'b0; sel = 2'd2; valid_in = 4'b0100; set_data(2, 8'hA5); ready_in = 1'b1;
    settle();
    chk("fix_ready", 32'(ready_out), 32'h4);
    tick();
    chk("fix_valid", 32'(valid_out), 32'h1);
    chk("fix_data", 32'(data_out), 32'hA5);
    chk("fix_chan", 32'(chan_out), 32'h2);
    valid_in = '0;
    tick();
    chk("fix_drain", 32'(valid_out), 32'h0);

    // Fixed select ch1 with output stall
    sel = 2'd1; valid_in = 4'b1111; set_data(1, 8'h11); ready_in = 1'b0;
    settle();
    chk("stall_ready_empty", 32'(ready_out), 32'h2);
    tick();
    set_data(1, 8'h12);
    chk("stall_first", 32'(data_out), 32'h11);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_data", 32'(data_out), 32'h11);
      chk("stall_hold_valid", 32'(valid_out), 32'h1);
      chk("stall_hold_ready", 32'(ready_out), 32'h0);
    end
    ready_in = 1'b1;
    settle();
    chk("stall_release_ready", 32'(ready_out), 32'h2);
    tick();
    chk("stall_beat2", 32'(data_out), 32'h12);
    set_data(1, 8'h13);
    tick();
    chk("stall_beat3", 32'(data_out), 32'h13);
    chk("stall_beat3_valid", 32'(valid_out), 32'h1);
    valid_in = '0;
    tick();
    chk("stall_drain", 32'(valid_out), 32'h0);
    chk("fix_ptr_kept", 32'(dbg_ptr), 32'h0);

    // Round-robin, all channels valid, no idle cycles
    mode = 1'b1; valid_in = 4'b1111; ready_in = 1'b1;
    for (int c = 0; c < NUM_CH; c++) set_data(c, 8'hC0 + 8'(c));
    for (int k = 0; k < 8; k++) exp_q.push_back(8'hC0 + 8'(k % NUM_CH));
    settle();
    chk("rr_first_ready", 32'(ready_out), 32'h1);
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_b = exp_q.pop_front();
      chk("rr_valid", 32'(valid_out), 32'h1);
      chk("rr_data", 32'(data_out), 32'(exp_b));
      chk("rr_chan", 32'(chan_out), 32'(exp_b[1:0]));
    end
    chk("rr_ptr_wrap", 32'(dbg_ptr), 32'h0);

    // Move ptr to 2 via one ch1 beat, then only ch3 and ch1 valid
    valid_in = 4'b0010;
    tick();
    chk("rr_ptr2_chan", 32'(chan_out), 32'h1);
    chk("rr_ptr2", 32'(dbg_ptr), 32'h2);
    valid_in = 4'b1010;
    settle();
    chk("rr31_ready_a", 32'(ready_out), 32'h8);
    tick();
    chk("rr31_chan_a", 32'(chan_out), 32'h3);
    chk("rr31_ptr_a", 32'(dbg_ptr), 32'h0);
    chk("rr31_ready_b", 32'(ready_out), 32'h2);
    tick();
    chk("rr31_chan_b", 32'(chan_out), 32'h1);
    chk("rr31_ptr_b", 32'(dbg_ptr), 32'h2);
    chk("rr31_ready_c", 32'(ready_out), 32'h8);

`ifdef STREAM_MUX_LOCK_EN
    // Packet lock: ch0 sends 3 beats while ch1 waits
    valid_in = 4'b0011; last_in = 4'b0000;
    set_data(0, 8'h01); set_data(1, 8'h21);
    settle();
    chk("lock_ready_b1", 32'(ready_out), 32'h1);
    tick();
    chk("lock_chan_b1", 32'(chan_out), 32'h0);
    chk("lock_data_b1", 32'(data_out), 32'h01);
    chk("lock_state_b1", 32'(dbg_locked), 32'h1);
    chk("lock_ready_b2", 32'(ready_out), 32'h1);
    set_data(0, 8'h02);
    tick();
    chk("lock_chan_b2", 32'(chan_out), 32'h0);
    chk("lock_data_b2", 32'(data_out), 32'h02);
    chk("lock_last_b2", 32'(last_out), 32'h0);
    set_data(0, 8'h03); last_in = 4'b0011;
    settle();
    chk("lock_ready_b3", 32'(ready_out), 32'h1);
    tick();
    chk("lock_chan_b3", 32'(chan_out), 32'h0);
    chk("lock_data_b3", 32'(data_out), 32'h03);
    chk("lock_last_b3", 32'(last_out), 32'h1);
    chk("lock_state_idle", 32'(dbg_locked), 32'h0);
    chk("lock_ready_ch1", 32'(ready_out), 32'h2);
    valid_in = 4'b0010;
    tick();
    chk("lock_chan_ch1", 32'(chan_out), 32'h1);
    chk("lock_data_ch1", 32'(data_out), 32'h21);
    chk("lock_last_ch1", 32'(last_out), 32'h1);
    last_in = '0;
`endif

    // Reset while an output beat is held
    mode = 1'b0; sel = 2'd0; valid_in = 4'b0001; set_data(0, 8'h5A); ready_in = 1'b1;
    tick();
    valid_in = '0; ready_in = 1'b0;
    tick();
    chk("hold_before_rst_valid", 32'(valid_out), 32'h1);
    chk("hold_before_rst_data", 32'(data_out), 32'h5A);
    chk("ptr_before_rst", 32'(dbg_ptr), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(valid_out), 32'h0);
    chk("async_rst_data", 32'(data_out), 32'h0);
    chk("async_rst_chan", 32'(chan_out), 32'h0);
    chk("async_rst_ptr", 32'(dbg_ptr), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_valid", 32'(valid_out), 32'h0);
    chk("post_rst_ptr", 32'(dbg_ptr), 32'h0);
    chk("post_rst_locked", 32'(dbg_locked), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
